// File: rtl/tx_gearbox.sv
// 64b/66b transmit gearbox: 32 blocks of 66 bits in, 33 words of 64 bits out.
// Every 33rd cycle upstream pauses while the full residual drains.
module tx_gearbox (
    input  logic        clk,
    input  logic        reset,
    input  logic [65:0] data_in,
    output logic        in_ready,
    output logic [63:0] data_out,
    output logic        out_valid,
    output logic [5:0]  seq_cnt
);
    localparam logic [5:0] LAST = 6'd32;

    logic [63:0]  residual;
    logic [6:0]   r;
    logic [127:0] cat;
    logic         pause;

    assign pause    = (seq_cnt == LAST);
    assign in_ready = !reset && !pause;

    // Fill level is always two bits per accepted block.
    assign r   = {seq_cnt, 1'b0};
    assign cat = ({62'b0, data_in} << r) | {64'b0, residual};

    always_ff @(posedge clk) begin
        if (reset) begin
            seq_cnt   <= '0;
            residual  <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b1;
            if (pause) begin
                data_out <= residual;
                residual <= '0;
                seq_cnt  <= '0;
            end else begin
                data_out <= cat[63:0];
                residual <= cat[127:64];
                seq_cnt  <= seq_cnt + 6'd1;
            end
        end
    end
endmodule

// File: tb/tb_tx_gearbox.sv
// Directed and frame-level checks for the 66-to-64 transmit gearbox.
// Frames are rebuilt as 2112-bit LSB-first streams and sliced both ways.
module tb_tx_gearbox;
    logic        clk = 1'b0;
    logic        reset;
    logic [65:0] data_in;
    logic        in_ready;
    logic [63:0] data_out;
    logic        out_valid;
    logic [5:0]  seq_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tx_gearbox dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .seq_cnt   (seq_cnt)
    );

    typedef struct {
        logic        rst;
        logic [65:0] din;
        logic        rdy;
        logic [63:0] dout;
        logic        vld;
        logic [5:0]  seq;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string name, input logic [65:0] act,
                       input logic [65:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [65:0] rnd_blk();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[65:0];
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        data_in = '0;
        tick();
        reset = 1'b0;
    endtask

    // Runs one frame from seq 0; blocks are counting or random.
    task automatic run_frame(input bit rnd, input string tag);
        logic [65:0]   blk [32];
        logic [2111:0] sent;
        logic [2111:0] got;
        for (int k = 0; k < 32; k++) begin
            blk[k] = rnd ? rnd_blk() : {2'(k), 32'(k), 32'(k) ^ 32'hA5A5_0000};
            sent[66*k +: 66] = blk[k];
        end
        for (int k = 0; k < 33; k++) begin
            data_in = (k < 32) ? blk[k] : rnd_blk();
            #1;
            chk({tag, "_ready"}, 66'(in_ready), 66'(k != 32));
            tick();
            got[64*k +: 64] = data_out;
            chk({tag, "_valid"}, 66'(out_valid), 66'd1);
        end
        chk({tag, "_wrap"}, 66'(seq_cnt), 66'd0);
        if (!rnd) begin
            for (int j = 0; j < 33; j++)
                chk({tag, "_word"}, 66'(got[64*j +: 64]),
                    66'(sent[64*j +: 64]));
        end else begin
            for (int k = 0; k < 32; k++)
                chk({tag, "_rxblk"}, got[66*k +: 66], blk[k]);
        end
    endtask

    initial begin
        logic [65:0] b;
        reset = 1'b1;
        data_in = '0;

        vt[0] = '{1'b1, 66'h0, 1'b0, 64'h0, 1'b0, 6'd0};
        vt[1] = '{1'b0, 66'h2_0123456789ABCDEF, 1'b1,
                  64'h0123456789ABCDEF, 1'b1, 6'd1};
        vt[2] = '{1'b1, 66'h0, 1'b0, 64'h0, 1'b0, 6'd0};
        vt[3] = '{1'b0, 66'h1_FFFFFFFFFFFFFFFF, 1'b1,
                  64'hFFFFFFFFFFFFFFFF, 1'b1, 6'd1};
        vt[4] = '{1'b0, 66'h2_0000000000000000, 1'b1,
                  64'h0000000000000001, 1'b1, 6'd2};
        vt[5] = '{1'b0, 66'h3_AAAAAAAAAAAAAAAA, 1'b1,
                  64'hAAAAAAAAAAAAAAA8, 1'b1, 6'd3};

        tick();
        for (int i = 0; i < 6; i++) begin
            reset = vt[i].rst;
            data_in = vt[i].din;
            #1;
            chk($sformatf("v%0d_ready", i), 66'(in_ready), 66'(vt[i].rdy));
            tick();
            chk($sformatf("v%0d_dout", i), 66'(data_out), 66'(vt[i].dout));
            chk($sformatf("v%0d_valid", i), 66'(out_valid), 66'(vt[i].vld));
            chk($sformatf("v%0d_seq", i), 66'(seq_cnt), 66'(vt[i].seq));
        end

        do_reset();
        run_frame(1'b0, "count");
        for (int f = 0; f < 10; f++)
            run_frame(1'b1, $sformatf("rnd%0d", f));

        // Mid-frame reset at seq 17 drops residual bits.
        for (int k = 0; k < 17; k++) begin
            data_in = rnd_blk();
            tick();
        end
        chk("pre_rst_seq", 66'(seq_cnt), 66'd17);
        reset = 1'b1;
        data_in = rnd_blk();
        tick();
        chk("mid_rst_dout", 66'(data_out), 66'h0);
        chk("mid_rst_valid", 66'(out_valid), 66'h0);
        chk("mid_rst_seq", 66'(seq_cnt), 66'h0);
        reset = 1'b0;
        b = 66'h3_0F1E2D3C4B5A6978;
        data_in = b;
        tick();
        chk("post_rst_dout", 66'(data_out), 66'(b[63:0]));
        chk("post_rst_valid", 66'(out_valid), 66'h1);
        chk("post_rst_seq", 66'(seq_cnt), 66'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
